cu_mul_seq: RTL and testbench

Iterative shift-add multiplier for the compute unit, sitting directly upstream of the crossbar. It takes both operands from the crossbar read ports, computes a signed or unsigned DATA_WIDTH×DATA_WIDTH product over DATA_WIDTH+1 cycles, and presents the (optionally saturated) low word on the crossbar's multiplier data input. The sequencer uses the busy and done flags to stall and to assert the multiplier write enable.

---
 rtl/cu_mul_seq_pkg.sv | 12 +
 rtl/cu_mul_sat.sv | 39 +++
 rtl/cu_mul_seq.sv | 125 ++++++++++++
 tb/tb_cu_mul_seq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_mul_seq_pkg.sv
// rtl/cu_mul_seq_pkg.sv - shared state encoding and default width for the sequential multiplier
package cu_mul_seq_pkg;

    localparam int MUL_DEF_WIDTH = 16;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_CALC = 2'd1,
        MUL_FIN  = 2'd2
    } mul_state_e;

endpackage

// File: rtl/cu_mul_sat.sv
// rtl/cu_mul_sat.sv - overflow detection and saturation of a double-width product
module cu_mul_sat #(
    parameter int DATA_WIDTH = 16
) (
    input  logic [2*DATA_WIDTH-1:0] prod_i,
    input  logic                    sgn_i,
    input  logic                    sat_i,
    input  logic                    neg_i,
    output logic [DATA_WIDTH-1:0]   res_o,
    output logic                    ovf_o
);

    localparam int W = DATA_WIDTH;

    logic [W-1:0] hi_u;
    logic [W:0]   hi_s;
    logic         ovf_u;
    logic         ovf_s;

    // Unsigned results overflow on any upper-word bit; signed results must be a pure sign extension.
    always_comb begin
        hi_u  = prod_i[2*W-1:W];
        hi_s  = prod_i[2*W-1:W-1];
        ovf_u = (hi_u != '0);
        ovf_s = !((hi_s == '0) || (hi_s == '1));
        ovf_o = sgn_i ? ovf_s : ovf_u;
        res_o = prod_i[W-1:0];
        if (ovf_o && sat_i) begin
            if (!sgn_i) begin
                res_o = '1;
            end else if (neg_i) begin
                res_o = {1'b1, {(W-1){1'b0}}};
            end else begin
                res_o = {1'b0, {(W-1){1'b1}}};
            end
        end
    end

endmodule

// File: rtl/cu_mul_seq.sv
// rtl/cu_mul_seq.sv - iterative shift-add signed/unsigned multiplier with optional saturation
module cu_mul_seq
    import cu_mul_seq_pkg::*;
#(
    parameter int DATA_WIDTH = MUL_DEF_WIDTH
) (
    input  logic                  clk_dcd,
    input  logic                  rst_n,
    input  logic                  ps_mul_en,
    input  logic                  ps_mul_sgn,
    input  logic                  ps_mul_sat,
    input  logic                  ps_mul_clr,
    input  logic [DATA_WIDTH-1:0] xb_dtx,
    input  logic [DATA_WIDTH-1:0] xb_dty,
    output logic [DATA_WIDTH-1:0] mul_xb_dt,
    output logic                  mul_ps_busy,
    output logic                  mul_ps_done,
    output logic                  mul_ps_ovf
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    mul_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2*W-1:0]   acc_q;
    logic [2*W-1:0]   mcand_q;
    logic [W-1:0]     mplier_q;
    logic             sgn_q;
    logic             sat_q;
    logic             neg_q;
    logic [W-1:0]     res_q;
    logic             ovf_q;
    logic             done_q;

    logic [W-1:0]     x_mag_d;
    logic [W-1:0]     y_mag_d;
    logic             neg_d;
    logic [2*W-1:0]   prod_d;
    logic [W-1:0]     sat_res;
    logic             sat_ovf;

    // Operand magnitudes at start and the signed product at FIN; a zero magnitude negates to +0.
    always_comb begin
        x_mag_d = (ps_mul_sgn && xb_dtx[W-1]) ? -xb_dtx : xb_dtx;
        y_mag_d = (ps_mul_sgn && xb_dty[W-1]) ? -xb_dty : xb_dty;
        neg_d   = ps_mul_sgn & (xb_dtx[W-1] ^ xb_dty[W-1]);
        prod_d  = neg_q ? -acc_q : acc_q;
    end

    cu_mul_sat #(
        .DATA_WIDTH(W)
    ) u_sat (
        .prod_i (prod_d),
        .sgn_i  (sgn_q),
        .sat_i  (sat_q),
        .neg_i  (neg_q),
        .res_o  (sat_res),
        .ovf_o  (sat_ovf)
    );

    // Sequencer and datapath: latch at start, one multiplier bit per CALC cycle, register result at FIN.
    always_ff @(posedge clk_dcd or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MUL_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            sgn_q    <= 1'b0;
            sat_q    <= 1'b0;
            neg_q    <= 1'b0;
            res_q    <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (ps_mul_clr) begin
                state_q <= MUL_IDLE;
            end else begin
                case (state_q)
                    MUL_IDLE: begin
                        if (ps_mul_en) begin
                            sgn_q    <= ps_mul_sgn;
                            sat_q    <= ps_mul_sat;
                            neg_q    <= neg_d;
                            mcand_q  <= {{W{1'b0}}, x_mag_d};
                            mplier_q <= y_mag_d;
                            acc_q    <= '0;
                            cnt_q    <= '0;
                            state_q  <= MUL_CALC;
                        end
                    end
                    MUL_CALC: begin
                        if (mplier_q[0]) begin
                            acc_q <= acc_q + mcand_q;
                        end
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_LAST) begin
                            state_q <= MUL_FIN;
                        end
                    end
                    MUL_FIN: begin
                        res_q   <= sat_res;
                        ovf_q   <= sat_ovf;
                        done_q  <= 1'b1;
                        state_q <= MUL_IDLE;
                    end
                    default: begin
                        state_q <= MUL_IDLE;
                    end
                endcase
            end
        end
    end

    assign mul_ps_busy = (state_q != MUL_IDLE);
    assign mul_xb_dt   = res_q;
    assign mul_ps_ovf  = ovf_q;
    assign mul_ps_done = done_q;

endmodule

// File: tb/tb_cu_mul_seq.sv
// tb/tb_cu_mul_seq.sv - scoreboard bench for cu_mul_seq with an arithmetic reference model
module tb_cu_mul_seq;

    localparam int W = 16;

    logic         clk_dcd = 1'b0;
    logic         rst_n   = 1'b0;
    logic         en      = 1'b0;
    logic         sgn     = 1'b0;
    logic         sat     = 1'b0;
    logic         clr     = 1'b0;
    logic [W-1:0] x       = '0;
    logic [W-1:0] y       = '0;
    logic [W-1:0] mul_xb_dt;
    logic         mul_ps_busy;
    logic         mul_ps_done;
    logic         mul_ps_ovf;

    cu_mul_seq #(.DATA_WIDTH(W)) dut (
        .clk_dcd     (clk_dcd),
        .rst_n       (rst_n),
        .ps_mul_en   (en),
        .ps_mul_sgn  (sgn),
        .ps_mul_sat  (sat),
        .ps_mul_clr  (clr),
        .xb_dtx      (x),
        .xb_dty      (y),
        .mul_xb_dt   (mul_xb_dt),
        .mul_ps_busy (mul_ps_busy),
        .mul_ps_done (mul_ps_done),
        .mul_ps_ovf  (mul_ps_ovf)
    );

    always #5 clk_dcd = ~clk_dcd;

    typedef struct {
        logic [W-1:0] r;
        logic         o;
        int           edge_n;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   e      = 0;
    bit   m_act  = 1'b0;
    int   m_end  = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, e);
        end
    endtask

    function automatic void ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic s, input logic t,
                                    output logic [W-1:0] r, output logic o);
        longint pa, pb, p, lim;
        pa = longint'(a);
        pb = longint'(b);
        if (s && a[W-1]) pa = pa - (longint'(1) << W);
        if (s && b[W-1]) pb = pb - (longint'(1) << W);
        p = pa * pb;
        if (s) begin
            lim = longint'(1) << (W - 1);
            o = (p > lim - 1) || (p < -lim);
        end else begin
            o = p > ((longint'(1) << W) - 1);
        end
        r = p[W-1:0];
        if (o && t) begin
            if (!s)        r = '1;
            else if (p < 0) r = {1'b1, {(W-1){1'b0}}};
            else           r = {1'b0, {(W-1){1'b1}}};
        end
    endfunction

    // Reference model: one operation in flight, accepted only when idle, aborted by clr.
    initial begin
        logic [W-1:0] r;
        logic         o;
        forever begin
            @(posedge clk_dcd);
            e++;
            if (rst_n) begin
                if (m_act && e <= m_end) begin
                    if (clr) begin
                        if (q.size() > 0) void'(q.pop_back());
                        m_act = 1'b0;
                    end
                end else begin
                    m_act = 1'b0;
                    if (en && !clr) begin
                        ref_mul(x, y, sgn, sat, r, o);
                        q.push_back('{r: r, o: o, edge_n: e + W + 1});
                        m_act = 1'b1;
                        m_end = e + W + 1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge rst_n);
            q.delete();
            m_act = 1'b0;
        end
    end

    // Monitor: compares busy every cycle and pops the scoreboard on each done pulse.
    initial begin
        exp_t ex;
        forever begin
            @(negedge clk_dcd);
            if (rst_n) begin
                chk("busy", mul_ps_busy, (m_act && e < m_end) ? 1 : 0);
                if (mul_ps_done) begin
                    if (q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        ex = q.pop_front();
                        chk("done_edge", e, ex.edge_n);
                        chk("result", mul_xb_dt, ex.r);
                        chk("ovf", mul_ps_ovf, ex.o);
                    end
                end else if (q.size() > 0 && q[0].edge_n <= e) begin
                    chk("missing_done", 0, 1);
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_dcd);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && mul_ps_busy; i++) tick();
        chk("idle_timeout", mul_ps_busy, 0);
    endtask

    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic t);
        en = 1'b1; x = a; y = b; sgn = s; sat = t;
        tick();
        en = 1'b0; x = W'($urandom); y = W'($urandom); sgn = 1'($urandom); sat = 1'($urandom);
    endtask

    task automatic directed(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic s, input logic t, input logic [W-1:0] er, input logic eo);
        bit got;
        wait_idle();
        start(a, b, s, t);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk_dcd);
            if (mul_ps_done) begin
                got = 1'b1;
                chk({nm, "_res"}, mul_xb_dt, er);
                chk({nm, "_ovf"}, mul_ps_ovf, eo);
            end
        end
        chk({nm, "_done_seen"}, got, 1);
        tick();
    endtask

    initial begin
        tick();
        tick();
        chk("rst_res", mul_xb_dt, 0);
        chk("rst_busy", mul_ps_busy, 0);
        chk("rst_done", mul_ps_done, 0);
        chk("rst_ovf", mul_ps_ovf, 0);
        rst_n = 1'b1;
        tick();

        directed("u_ff_101",    16'h00FF, 16'h0101, 1'b0, 1'b0, 16'hFFFF, 1'b0);
        directed("u_ovf_wrap",  16'h1000, 16'h0010, 1'b0, 1'b0, 16'h0000, 1'b1);
        directed("u_ovf_sat",   16'h1000, 16'h0010, 1'b0, 1'b1, 16'hFFFF, 1'b1);
        directed("s_min_wrap",  16'h8000, 16'hFFFF, 1'b1, 1'b0, 16'h8000, 1'b1);
        directed("s_min_sat",   16'h8000, 16'hFFFF, 1'b1, 1'b1, 16'h7FFF, 1'b1);
        directed("s_min_one",   16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b0);
        directed("s_neg_zero",  16'hFFFD, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0);
        directed("s_neg_four",  16'hFFFD, 16'h0004, 1'b1, 1'b0, 16'hFFF4, 1'b0);

        // Abort during CALC: result register must hold the previous value.
        wait_idle();
        start(16'h1234, 16'h0FF0, 1'b0, 1'b0);
        repeat (8) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_busy", mul_ps_busy, 0);
        repeat (20) tick();
        chk("clr_hold_res", mul_xb_dt, 16'hFFF4);
        chk("clr_hold_ovf", mul_ps_ovf, 0);

        // clr beats en in the same idle cycle.
        en = 1'b1; clr = 1'b1;
        tick();
        en = 1'b0; clr = 1'b0;
        chk("clr_over_en", mul_ps_busy, 0);

        // en held high: back-to-back starts, pulses while busy ignored.
        en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            x = W'($urandom); y = W'($urandom); sgn = 1'($urandom); sat = 1'($urandom);
            tick();
        end
        en = 1'b0;
        wait_idle();

        // Asynchronous reset in the middle of CALC.
        start(16'h7FFF, 16'h7FFF, 1'b1, 1'b0);
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", mul_ps_busy, 0);
        chk("arst_done", mul_ps_done, 0);
        chk("arst_res", mul_xb_dt, 0);
        chk("arst_ovf", mul_ps_ovf, 0);
        @(posedge clk_dcd);
        #1;
        rst_n = 1'b1;
        tick();
        directed("post_rst", 16'h00FF, 16'h0101, 1'b0, 1'b0, 16'hFFFF, 1'b0);

        // Free-running random stream with sparse clr.
        for (int i = 0; i < 3000; i++) begin
            en  = ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 60) == 0);
            x   = W'($urandom);
            y   = W'($urandom);
            sgn = 1'($urandom);
            sat = 1'($urandom);
            if ($urandom_range(0, 7) == 0) x = ($urandom_range(0, 1) == 0) ? 16'h8000 : 16'h0000;
            tick();
        end
        en = 1'b0; clr = 1'b0;
        repeat (40) tick();
        chk("drain", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
